// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor.
package sub_pkg;

   localparam int unsigned DEF_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, with borrow out.
module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   // Difference bit and borrow generated from the current bit pair and incoming borrow
   always_comb begin
      d    = a ^ b ^ bin;
      bout = (~a & b) | (~(a ^ b) & bin);
   end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b, LSB first, one bit per cycle.
module serial_subtractor
   import sub_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out
);

   localparam int unsigned    CW   = $clog2(WIDTH);
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] diff_sr;
   logic             bflop;
   logic [CW-1:0]    cnt;
   logic             d;
   logic             bnext;

   full_subtractor u_fs (
      .a    (a_sr[0]),
      .b    (b_sr[0]),
      .bin  (bflop),
      .d    (d),
      .bout (bnext)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic and state-decoded handshake outputs
   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE:  if (start) state_nxt = SHIFT;
         SHIFT: begin
            busy = 1'b1;
            if (cnt == LAST) state_nxt = DONE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Operand capture, serial shifting and result update on the final shift edge
   always_ff @(posedge clk) begin
      if (rst) begin
         a_sr       <= '0;
         b_sr       <= '0;
         diff_sr    <= '0;
         bflop      <= 1'b0;
         cnt        <= '0;
         diff       <= '0;
         borrow_out <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_sr  <= a;
                  b_sr  <= b;
                  bflop <= 1'b0;
                  cnt   <= '0;
               end
            end
            SHIFT: begin
               a_sr    <= a_sr >> 1;
               b_sr    <= b_sr >> 1;
               diff_sr <= {d, diff_sr[WIDTH-1:1]};
               bflop   <= bnext;
               cnt     <= cnt + CW'(1);
               if (cnt == LAST) begin
                  diff       <= {d, diff_sr[WIDTH-1:1]};
                  borrow_out <= bnext;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8 and WIDTH=2) and full_subtractor.
module tb_serial_subtractor;

   logic       clk = 1'b0;
   logic       rst;
   logic       start8, busy8, done8, bo8;
   logic [7:0] a8, b8, diff8;
   logic       start2, busy2, done2, bo2;
   logic [1:0] a2, b2, diff2;
   logic       fa, fb, fbin, fd, fbout;

   int         vectors     = 0;
   int         miscompares = 0;
   int         done8_cnt   = 0;
   int         done2_cnt   = 0;
   logic [8:0] q8[$];
   logic [2:0] q2[$];
   logic [8:0] e8;
   logic [2:0] e2;

   always #5 clk = ~clk;

   serial_subtractor #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
      .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bo8)
   );

   serial_subtractor #(.WIDTH(2)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2),
      .busy(busy2), .done(done2), .diff(diff2), .borrow_out(bo2)
   );

   full_subtractor u_fs (
      .a(fa), .b(fb), .bin(fbin), .d(fd), .bout(fbout)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Scoreboard for the 8-bit instance
   always @(negedge clk) begin
      if (done8 === 1'b1) begin
         done8_cnt++;
         if (q8.size() == 0) chk("done8_unexpected", 32'd1, 32'd0);
         else begin
            e8 = q8.pop_front();
            chk("diff8", 32'(diff8), 32'(e8[7:0]));
            chk("borrow8", 32'(bo8), 32'(e8[8]));
         end
      end
   end

   // Scoreboard for the 2-bit instance
   always @(negedge clk) begin
      if (done2 === 1'b1) begin
         done2_cnt++;
         if (q2.size() == 0) chk("done2_unexpected", 32'd1, 32'd0);
         else begin
            e2 = q2.pop_front();
            chk("diff2", 32'(diff2), 32'(e2[1:0]));
            chk("borrow2", 32'(bo2), 32'(e2[2]));
         end
      end
   end

   function automatic logic [8:0] model8(input logic [7:0] x, input logic [7:0] y);
      logic [7:0] dd;
      dd = x - y;
      return {x < y, dd};
   endfunction

   function automatic logic [2:0] model2(input logic [1:0] x, input logic [1:0] y);
      logic [1:0] dd;
      dd = x - y;
      return {x < y, dd};
   endfunction

   task automatic op8(input logic [7:0] x, input logic [7:0] y);
      int busy_n = 0;
      int done_at = 0;
      @(negedge clk);
      a8 = x; b8 = y; start8 = 1'b1;
      q8.push_back(model8(x, y));
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         start8 = 1'b0;
         if (i == 2) begin
            a8 = 8'($urandom);
            b8 = 8'($urandom);
         end
         if (busy8 === 1'b1) busy_n++;
         if (done8 === 1'b1 && done_at == 0) done_at = i;
      end
      chk("busy8_len", 32'(busy_n), 32'd8);
      chk("done8_at", 32'(done_at), 32'd9);
   endtask

   task automatic op2(input logic [1:0] x, input logic [1:0] y);
      int done_at = 0;
      @(negedge clk);
      a2 = x; b2 = y; start2 = 1'b1;
      q2.push_back(model2(x, y));
      for (int i = 1; i <= 6; i++) begin
         @(negedge clk);
         start2 = 1'b0;
         if (done2 === 1'b1 && done_at == 0) done_at = i;
      end
      chk("done2_at", 32'(done_at), 32'd3);
   endtask

   initial begin
      int cnt0;
      int done_at;
      int dts[$];

      rst = 1'b1; start8 = 1'b0; start2 = 1'b0;
      a8 = '0; b8 = '0; a2 = '0; b2 = '0;
      fa = 1'b0; fb = 1'b0; fbin = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_busy", 32'(busy8), 32'd0);
      chk("rst_done", 32'(done8), 32'd0);
      chk("rst_diff", 32'(diff8), 32'd0);
      chk("rst_borrow", 32'(bo8), 32'd0);
      rst = 1'b0;

      // Full subtractor: all input combinations
      for (int v = 0; v < 8; v++) begin
         int t;
         {fa, fb, fbin} = 3'(v);
         #1;
         t = int'(fa) - int'(fb) - int'(fbin);
         chk("fs_d", 32'(fd), 32'(t & 1));
         chk("fs_bout", 32'(fbout), (t < 0) ? 32'd1 : 32'd0);
      end

      // Directed operand patterns
      op8(8'h5A, 8'h23);
      op8(8'h00, 8'h01);
      op8(8'hFF, 8'h00);
      op8(8'h80, 8'h80);
      op8(8'h01, 8'hFF);

      // Start during SHIFT is ignored; a/b changes after capture have no effect
      cnt0 = done8_cnt;
      done_at = 0;
      @(negedge clk);
      a8 = 8'h10; b8 = 8'h01; start8 = 1'b1;
      q8.push_back(model8(8'h10, 8'h01));
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         start8 = (i == 3);
         if (i == 3) begin a8 = 8'h00; b8 = 8'hFF; end
         if (done8 === 1'b1 && done_at == 0) done_at = i;
      end
      chk("collide_done_at", 32'(done_at), 32'd9);
      chk("collide_done_count", 32'(done8_cnt - cnt0), 32'd1);

      // Reset during SHIFT discards the operation
      @(negedge clk);
      a8 = 8'h33; b8 = 8'h11; start8 = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         start8 = 1'b0;
         if (i == 4) rst = 1'b1;
      end
      @(negedge clk);
      chk("midrst_busy", 32'(busy8), 32'd0);
      chk("midrst_done", 32'(done8), 32'd0);
      chk("midrst_diff", 32'(diff8), 32'd0);
      chk("midrst_borrow", 32'(bo8), 32'd0);
      rst = 1'b0;
      cnt0 = done8_cnt;
      repeat (12) @(negedge clk);
      chk("midrst_no_done", 32'(done8_cnt - cnt0), 32'd0);
      op8(8'h09, 8'h03);

      // Start held high: back-to-back operations every WIDTH+2 cycles
      @(negedge clk);
      a8 = 8'h20; b8 = 8'h10; start8 = 1'b1;
      repeat (3) q8.push_back(model8(8'h20, 8'h10));
      for (int i = 1; i <= 30; i++) begin
         @(negedge clk);
         if (i == 21) start8 = 1'b0;
         if (done8 === 1'b1) dts.push_back(i);
      end
      chk("held_done_count", 32'(dts.size()), 32'd3);
      if (dts.size() == 3) begin
         chk("held_first_done", 32'(dts[0]), 32'd9);
         chk("held_period1", 32'(dts[1] - dts[0]), 32'd10);
         chk("held_period2", 32'(dts[2] - dts[1]), 32'd10);
      end

      // WIDTH=2 exhaustive operand pairs
      for (int x = 0; x < 4; x++)
         for (int y = 0; y < 4; y++)
            op2(2'(x), 2'(y));

      repeat (3) @(negedge clk);
      chk("q8_drained", 32'(q8.size()), 32'd0);
      chk("q2_drained", 32'(q2.size()), 32'd0);
      chk("done2_total", 32'(done2_cnt), 32'd16);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
